// File: rtl/nios_gpio.sv
// nios_gpio: Avalon-MM general-purpose I/O port with per-bit direction,
//   atomic output set/clear, synchronised inputs and optional edge capture
//   that drives a level interrupt.
// Latency: zero-wait-state slave. readdata is combinational from address.
//   Register writes take effect on the write edge. Input-to-DATA takes
//   SYNC_STAGES cycles. Input edge to EDGECAP takes SYNC_STAGES+1 cycles.
//   EDGECAP to irq takes 1 cycle.
// Backpressure: none. Every access completes in the cycle it is presented.
//
// Ports:
//   clk, reset_n                     - system clock, async active-low reset
//   address, chipselect, write_n     - Avalon-MM slave control
//   writedata, readdata              - 32-bit data; bits above WIDTH are
//                                      ignored on writes and read as 0
//   in_port                          - asynchronous pad inputs
//   out_port, oe                     - output data register and direction
//                                      (1 = driven)
//   irq                              - level interrupt to the CPU
//
// Build option: define NIOS_GPIO_EDGE_IRQ_EN to build IRQMASK, EDGECAP,
// the in_prev register and the irq logic. Without it, addresses 2 and 3
// read 0 and ignore writes, and irq is tied low.

module nios_gpio #(
  parameter int               WIDTH       = 17,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '1,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  logic             wr;
  logic [WIDTH-1:0] wdat;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] rd_val;

  // Upper writedata bits are architecturally ignored when WIDTH < 32.
  logic unused_wdat;
  assign unused_wdat = ^writedata;

  assign wr   = chipselect & ~write_n;
  assign wdat = writedata[WIDTH-1:0];

  assign out_port = data_out;
  assign oe       = dir;

  // Output data and direction registers. OUTSET/OUTCLR give the CPU
  // read-modify-write-free bit manipulation of the output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= OUT_RESET;
      dir      <= DIR_RESET;
    end else if (wr) begin
      case (address)
        ADDR_DATA:   data_out <= wdat;
        ADDR_DIR:    dir      <= wdat;
        ADDR_OUTSET: data_out <= data_out | wdat;
        ADDR_OUTCLR: data_out <= data_out & ~wdat;
        default:     ;
      endcase
    end
  end

  // Input synchroniser. Stage 0 takes the pad; the last stage is in_sync.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
    end
  end

  assign in_sync = sync_q[SYNC_STAGES-1];

`ifdef NIOS_GPIO_EDGE_IRQ_EN
  logic [WIDTH-1:0] in_prev;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] cap_clr;
  logic             irq_q;

  // Edge detection looks only at the synchronised pad value, so bits that
  // are driven as outputs see their own transitions only via the board.
  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      0:       edge_det = in_sync & ~in_prev;
      1:       edge_det = ~in_sync & in_prev;
      default: edge_det = in_sync ^ in_prev;
    endcase
  end

  assign cap_clr = (wr && address == ADDR_EDGECAP) ? wdat : '0;

  // A fresh edge is ORed in after the clear, so it survives a
  // simultaneous write-1-clear of the same bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_prev <= '0;
      irqmask <= '0;
      edgecap <= '0;
      irq_q   <= 1'b0;
    end else begin
      in_prev <= in_sync;
      edgecap <= (edgecap & ~cap_clr) | edge_det;
      irq_q   <= |(edgecap & irqmask);
      if (wr && address == ADDR_IRQMASK) begin
        irqmask <= wdat;
      end
    end
  end

  assign irq = irq_q;
`else
  localparam int unused_edge_type = EDGE_TYPE;
  assign irq = 1'b0;
`endif

  // Read mux. DATA returns the driven value for output bits and the
  // synchronised pad for input bits. Write-only and reserved words read 0.
  always_comb begin
    rd_val = '0;
    case (address)
      ADDR_DATA:    rd_val = (data_out & dir) | (in_sync & ~dir);
      ADDR_DIR:     rd_val = dir;
`ifdef NIOS_GPIO_EDGE_IRQ_EN
      ADDR_IRQMASK: rd_val = irqmask;
      ADDR_EDGECAP: rd_val = edgecap;
`endif
      default:      rd_val = '0;
    endcase
  end

  always_comb begin
    readdata = '0;
    readdata[WIDTH-1:0] = rd_val;
  end

endmodule
